data_mem_ctrl: RTL and testbench

- Parametrised successor to the core's byte-addressed data memory for RV32I loads and stores.
- Sits between the execute/memory stage and a local byte-wide RAM array.
- Adds a valid/ready request handshake, a registered response with configurable latency, and correct LB/LH/LW/LBU/LHU/SB/SH/SW semantics.
- Reports misaligned, out-of-range and illegal accesses instead of silently corrupting memory.

---
 rtl/data_mem_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Byte-addressed RV32I data memory controller: valid/ready request, fault classification,
// LB/LH/LW/LBU/LHU/SB/SH/SW semantics and a registered response after RD_LAT cycles.
module data_mem_ctrl #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DEPTH_BYTES = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       RD_LAT      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_func3,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        rsp_err_code
);

    localparam int unsigned       OFF_W     = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int unsigned       EXT_W     = ADDR_W + 1;
    localparam logic [EXT_W-1:0]  BASE_EXT  = EXT_W'(BASE_ADDR);
    localparam logic [EXT_W-1:0]  DEPTH_EXT = EXT_W'(DEPTH_BYTES);
    localparam logic [1:0]        LAT_INIT  = 2'(RD_LAT - 1);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_MIS  = 2'b01;
    localparam logic [1:0] ERR_OOR  = 2'b10;
    localparam logic [1:0] ERR_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    state_e           state_q;
    logic [1:0]       cnt_q;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_rdata_q;
    logic             rsp_err_q;
    logic [1:0]       rsp_code_q;
    logic             we_q;
    logic [2:0]       f3_q;
    logic [OFF_W-1:0] off_q;
    logic [1:0]       code_q;

    logic [7:0]       mem [DEPTH_BYTES];

    logic             accept_c;
    logic [2:0]       size_c;
    logic [EXT_W-1:0] addr_ext_c;
    logic [EXT_W-1:0] off_ext_c;
    logic [EXT_W-1:0] end_ext_c;
    logic [1:0]       code_c;
    logic [OFF_W-1:0] off_c;

    logic [OFF_W-1:0] rd_off_c;
    logic [2:0]       rd_f3_c;
    logic             rd_ok_c;
    logic [3:0][7:0]  rb_c;
    logic [31:0]      ld_data_c;

    assign accept_c = req_valid && req_ready_q;

    // Classify the incoming request; the range check is done one bit wider so it never wraps
    always_comb begin
        addr_ext_c = EXT_W'(req_addr);
        off_ext_c  = addr_ext_c - BASE_EXT;
        case (req_func3[1:0])
            2'b00:   size_c = 3'd1;
            2'b01:   size_c = 3'd2;
            default: size_c = 3'd4;
        endcase
        end_ext_c = off_ext_c + EXT_W'(size_c);
        off_c     = off_ext_c[OFF_W-1:0];

        code_c = ERR_NONE;
        if ((req_func3[1:0] == 2'b11) || (req_func3 == 3'b110) || (req_we && req_func3[2])) begin
            code_c = ERR_ILL;
        end else if (((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))) begin
            code_c = ERR_MIS;
        end else if ((addr_ext_c < BASE_EXT) || (end_ext_c > DEPTH_EXT)) begin
            code_c = ERR_OOR;
        end
    end

    // Load path: with RD_LAT=1 the response is built straight from the live request
    always_comb begin
        if (state_q == ST_IDLE) begin
            rd_off_c = off_c;
            rd_f3_c  = req_func3;
            rd_ok_c  = !req_we && (code_c == ERR_NONE);
        end else begin
            rd_off_c = off_q;
            rd_f3_c  = f3_q;
            rd_ok_c  = !we_q && (code_q == ERR_NONE);
        end

        for (int i = 0; i < 4; i++) begin
            rb_c[i] = mem[rd_off_c + OFF_W'(i)];
        end

        ld_data_c = '0;
        if (rd_ok_c) begin
            case (rd_f3_c)
                3'b000:  ld_data_c = {{24{rb_c[0][7]}}, rb_c[0]};
                3'b001:  ld_data_c = {{16{rb_c[1][7]}}, rb_c[1], rb_c[0]};
                3'b010:  ld_data_c = {rb_c[3], rb_c[2], rb_c[1], rb_c[0]};
                3'b100:  ld_data_c = {24'h0, rb_c[0]};
                3'b101:  ld_data_c = {16'h0, rb_c[1], rb_c[0]};
                default: ld_data_c = '0;
            endcase
        end
    end

    // Store bytes commit on the acceptance edge; RAM is intentionally not reset
    always_ff @(posedge clk) begin
        if (accept_c && req_we && (code_c == ERR_NONE)) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < size_c) begin
                    mem[off_c + OFF_W'(i)] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Request/response FSM: IDLE -> (WAIT) -> RESP -> IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_code_q  <= ERR_NONE;
            we_q        <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
            code_q      <= ERR_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept_c) begin
                        req_ready_q <= 1'b0;
                        we_q        <= req_we;
                        f3_q        <= req_func3;
                        off_q       <= off_c;
                        code_q      <= code_c;
                        if (RD_LAT <= 1) begin
                            state_q     <= ST_RESP;
                            cnt_q       <= '0;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= ld_data_c;
                            rsp_err_q   <= (code_c != ERR_NONE);
                            rsp_code_q  <= code_c;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= LAT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= ld_data_c;
                        rsp_err_q   <= (code_q != ERR_NONE);
                        rsp_code_q  <= code_q;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_err_code = rsp_code_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (RD_LAT=1 and RD_LAT=3) checked against a
// byte-array reference model, a directed vector table, stall/reset sequences and random ops.
module tb_data_mem_ctrl;

    localparam int unsigned DEPTH = 1024;
    localparam longint      BASE  = 0;

    logic        clk;
    logic        rst_n;
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [31:0] req_addr     [2];
    logic [2:0]  req_func3    [2];
    logic [31:0] req_wdata    [2];
    logic        rsp_valid    [2];
    logic        rsp_ready    [2];
    logic [31:0] rsp_rdata    [2];
    logic        rsp_err      [2];
    logic [1:0]  rsp_err_code [2];

    int checks;
    int failures;
    int lat_of [2];

    logic [7:0] mdl [2][DEPTH];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [1:0]  exp_code;
    } vec_t;

    vec_t vt [20];

    data_mem_ctrl #(.ADDR_W(32), .DEPTH_BYTES(DEPTH), .BASE_ADDR(32'h0), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_func3(req_func3[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .rsp_err_code(rsp_err_code[0])
    );

    data_mem_ctrl #(.ADDR_W(32), .DEPTH_BYTES(DEPTH), .BASE_ADDR(32'h0), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_func3(req_func3[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .rsp_err_code(rsp_err_code[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference behaviour straight from the access rules, on a flat byte array
    task automatic model_op(input int s, input logic we, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] code);
        int     size;
        longint off;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off  = {32'h0, addr};
        off  = off - BASE;
        rd   = '0;
        code = 2'd0;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (we && f3 >= 3'd4)) begin
            code = 2'd3;
        end else if ((int'(addr[1:0]) % size) != 0) begin
            code = 2'd1;
        end else if (off < 0 || off + size > DEPTH) begin
            code = 2'd2;
        end else if (we) begin
            for (int i = 0; i < size; i++) mdl[s][int'(off) + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < size; i++) rd[8*i +: 8] = mdl[s][int'(off) + i];
            if (f3 == 3'd0 && rd[7])  rd = rd | 32'hFFFF_FF00;
            if (f3 == 3'd1 && rd[15]) rd = rd | 32'hFFFF_0000;
        end
    endtask

    task automatic wait_ready(input int s, output bit ok);
        int n;
        n = 0;
        while (!req_ready[s] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        ok = req_ready[s];
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout inst=%0d got=0 exp=1", s);
        end
    endtask

    task automatic drive_req(input int s, input logic we, input logic [31:0] addr,
                             input logic [2:0] f3, input logic [31:0] wd);
        req_valid[s] = 1'b1;
        req_we[s]    = we;
        req_addr[s]  = addr;
        req_func3[s] = f3;
        req_wdata[s] = wd;
    endtask

    // Issue one request, wait for the response, check latency and payload, then handshake
    task automatic do_op(input int s, input logic we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd, output logic [31:0] got_rd, output logic [1:0] got_code);
        bit          ok;
        int          n;
        logic [31:0] exp_rd;
        logic [1:0]  exp_code;
        got_rd   = '0;
        got_code = '0;
        wait_ready(s, ok);
        if (ok) begin
            model_op(s, we, addr, f3, wd, exp_rd, exp_code);
            drive_req(s, we, addr, f3, wd);
            rsp_ready[s] = 1'b1;
            @(posedge clk); #1;
            req_valid[s] = 1'b0;
            n = 1;
            while (!rsp_valid[s] && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            chk("latency", 32'(n), 32'(lat_of[s]));
            chk("rdata", rsp_rdata[s], exp_rd);
            chk("err", 32'(rsp_err[s]), 32'(exp_code != 2'd0));
            chk("err_code", 32'(rsp_err_code[s]), 32'(exp_code));
            got_rd   = rsp_rdata[s];
            got_code = rsp_err_code[s];
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  cd;
        logic [31:0] exp_rd;
        logic [1:0]  exp_code;
        logic [31:0] held;
        bit          ok;
        int          n;

        checks    = 0;
        failures  = 0;
        lat_of[0] = 1;
        lat_of[1] = 3;
        rst_n     = 1'b0;
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0; req_we[s] = 1'b0; req_addr[s] = '0;
            req_func3[s] = '0;   req_wdata[s] = '0; rsp_ready[s] = 1'b0;
        end

        // Directed vectors for the RD_LAT=1 instance
        vt[0]  = '{1'b1, 32'h010, 3'd2, 32'hDEADBEEF, 32'h0000_0000, 2'd0};
        vt[1]  = '{1'b0, 32'h010, 3'd2, 32'h0,        32'hDEADBEEF, 2'd0};
        vt[2]  = '{1'b0, 32'h013, 3'd0, 32'h0,        32'hFFFFFFDE, 2'd0};
        vt[3]  = '{1'b0, 32'h013, 3'd4, 32'h0,        32'h000000DE, 2'd0};
        vt[4]  = '{1'b0, 32'h012, 3'd1, 32'h0,        32'hFFFFDEAD, 2'd0};
        vt[5]  = '{1'b0, 32'h010, 3'd5, 32'h0,        32'h0000BEEF, 2'd0};
        vt[6]  = '{1'b1, 32'h011, 3'd0, 32'h12345677, 32'h0000_0000, 2'd0};
        vt[7]  = '{1'b0, 32'h010, 3'd2, 32'h0,        32'hDEAD77EF, 2'd0};
        vt[8]  = '{1'b0, 32'h012, 3'd2, 32'h0,        32'h0000_0000, 2'd1};
        vt[9]  = '{1'b1, 32'h3FC, 3'd2, 32'h11223344, 32'h0000_0000, 2'd0};
        vt[10] = '{1'b1, 32'h3FE, 3'd2, 32'hAAAAAAAA, 32'h0000_0000, 2'd1};
        vt[11] = '{1'b0, 32'h3FC, 3'd2, 32'h0,        32'h11223344, 2'd0};
        vt[12] = '{1'b0, 32'h400, 3'd2, 32'h0,        32'h0000_0000, 2'd2};
        vt[13] = '{1'b1, 32'h010, 3'd4, 32'hFFFFFFFF, 32'h0000_0000, 2'd3};
        vt[14] = '{1'b0, 32'h010, 3'd2, 32'h0,        32'hDEAD77EF, 2'd0};
        vt[15] = '{1'b0, 32'h3FE, 3'd1, 32'h0,        32'h00001122, 2'd0};
        vt[16] = '{1'b0, 32'h3FF, 3'd0, 32'h0,        32'h00000011, 2'd0};
        vt[17] = '{1'b0, 32'h400, 3'd0, 32'h0,        32'h0000_0000, 2'd2};
        vt[18] = '{1'b0, 32'h401, 3'd6, 32'h0,        32'h0000_0000, 2'd3};
        vt[19] = '{1'b0, 32'h401, 3'd1, 32'h0,        32'h0000_0000, 2'd1};

        // Reset values while rst_n is low
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_req_ready", 32'(req_ready[s]), 32'h0);
            chk("rst_rsp_valid", 32'(rsp_valid[s]), 32'h0);
            chk("rst_rsp_rdata", rsp_rdata[s], 32'h0);
            chk("rst_rsp_err", 32'(rsp_err[s]), 32'h0);
            chk("rst_err_code", 32'(rsp_err_code[s]), 32'h0);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Give both RAMs known contents
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < int'(DEPTH / 4); w++) begin
                do_op(s, 1'b1, 32'(w * 4), 3'd2, $urandom, rd, cd);
            end
        end

        for (int v = 0; v < 20; v++) begin
            do_op(0, vt[v].we, vt[v].addr, vt[v].f3, vt[v].wd, rd, cd);
            chk($sformatf("vec%0d_rdata", v), rd, vt[v].exp_rd);
            chk($sformatf("vec%0d_code", v), 32'(cd), 32'(vt[v].exp_code));
        end

        // RD_LAT=3: stalled response stays stable and ignores new request inputs
        do_op(1, 1'b1, 32'h10, 3'd2, 32'h0BADF00D, rd, cd);
        wait_ready(1, ok);
        if (ok) begin
            model_op(1, 1'b0, 32'h10, 3'd2, 32'h0, exp_rd, exp_code);
            drive_req(1, 1'b0, 32'h10, 3'd2, 32'h0);
            rsp_ready[1] = 1'b0;
            @(posedge clk); #1;
            req_valid[1] = 1'b0;
            n = 1;
            while (!rsp_valid[1] && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            chk("stall_latency", 32'(n), 32'd3);
            chk("stall_const_rdata", rsp_rdata[1], 32'h0BADF00D);
            held = rsp_rdata[1];
            drive_req(1, 1'b1, 32'h10, 3'd2, 32'h55555555);
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                chk("stall_valid", 32'(rsp_valid[1]), 32'h1);
                chk("stall_rdata", rsp_rdata[1], held);
                chk("stall_req_ready", 32'(req_ready[1]), 32'h0);
            end
            req_valid[1] = 1'b0;
            rsp_ready[1] = 1'b1;
            @(posedge clk); #1;
            chk("release_valid", 32'(rsp_valid[1]), 32'h0);
            chk("release_req_ready", 32'(req_ready[1]), 32'h1);
        end
        do_op(1, 1'b0, 32'h10, 3'd2, 32'h0, rd, cd);
        chk("stall_ignored_write", rd, 32'h0BADF00D);

        // Reset during WAIT of a store: store survives, transaction aborts
        wait_ready(1, ok);
        if (ok) begin
            model_op(1, 1'b1, 32'h20, 3'd2, 32'hCAFEF00D, exp_rd, exp_code);
            drive_req(1, 1'b1, 32'h20, 3'd2, 32'hCAFEF00D);
            rsp_ready[1] = 1'b1;
            @(posedge clk); #1;
            req_valid[1] = 1'b0;
            @(posedge clk); #1;
            chk("wait_valid", 32'(rsp_valid[1]), 32'h0);
            rst_n = 1'b0;
            #1;
            chk("wait_rst_valid", 32'(rsp_valid[1]), 32'h0);
            chk("wait_rst_req_ready", 32'(req_ready[1]), 32'h0);
            @(posedge clk); #1;
            rst_n = 1'b1;
        end
        do_op(1, 1'b0, 32'h20, 3'd2, 32'h0, rd, cd);
        chk("rst_store_kept", rd, 32'hCAFEF00D);

        // Reset during RESP drops rsp_valid asynchronously
        wait_ready(1, ok);
        if (ok) begin
            drive_req(1, 1'b0, 32'h20, 3'd2, 32'h0);
            rsp_ready[1] = 1'b0;
            @(posedge clk); #1;
            req_valid[1] = 1'b0;
            n = 1;
            while (!rsp_valid[1] && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            chk("resp_before_rst", 32'(rsp_valid[1]), 32'h1);
            #2;
            rst_n = 1'b0;
            #1;
            chk("resp_rst_valid", 32'(rsp_valid[1]), 32'h0);
            chk("resp_rst_rdata", rsp_rdata[1], 32'h0);
            @(posedge clk); #1;
            rst_n = 1'b1;
        end

        // Random traffic against the model
        for (int t = 0; t < 300; t++) begin
            int          s;
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr;
            s  = int'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8) begin
                case ($urandom_range(0, 4))
                    0:       f3 = 3'd0;
                    1:       f3 = 3'd1;
                    2:       f3 = 3'd2;
                    3:       f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            case ($urandom_range(0, 9))
                0:       addr = $urandom;
                1, 2, 3: addr = 32'h3F0 + 32'($urandom_range(0, 31));
                default: addr = 32'($urandom_range(0, 63));
            endcase
            do_op(s, we, addr, f3, $urandom, rd, cd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
